// File: rtl/bus_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bus_slot_scheduler
// Purpose  : 16-slot TDM scheduler splitting each 1 MHz CPU cycle between
//            video fetch, one Raspberry Pi access slot and the CPU phase.
// Revision : 1.0 - initial release
// ============================================================================
module bus_slot_scheduler #(
  parameter int VIDEO_EN         = 1,
  parameter int CPU_STROBE_START = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       bus_rw_b_i,
  input  logic       pi_rw_b_i,
  input  logic       pi_pending_i,
  output logic       phi2_o,
  output logic       clk8_o,
  output logic [3:0] cycle_o,
  output logic       cpu_enable_o,
  output logic       cpu_read_o,
  output logic       cpu_write_o,
  output logic       video_select_o,
  output logic       video_ram_strobe_o,
  output logic       video_rom_strobe_o,
  output logic       pi_select_o,
  output logic       pi_read_o,
  output logic       pi_write_o,
  output logic       pi_done_o
);

  localparam logic [3:0] c_cpu_start = 4'(CPU_STROBE_START);
  localparam logic       c_video_en  = (VIDEO_EN != 0);

  logic [3:0] r_slot;
  logic       r_clk8, r_served, r_grant, r_pi_rw, r_rw;
  logic       r_phi2, r_cpu_en, r_cpu_rd, r_cpu_wr;
  logic       r_vsel, r_vram, r_vrom;
  logic       r_pi_sel, r_pi_rd, r_pi_wr, r_pi_done;

  logic [3:0] w_slot_nxt;
  logic       w_grant_d, w_pi_rw_d, w_rw_d, w_served_d, w_cpu_win;

  // Outputs are registered from the slot being entered, so the "_d" terms
  // forward values that are captured on this same edge.
  always_comb begin
    w_slot_nxt = r_slot + 4'd1;
    w_grant_d  = (r_slot == 4'd5) ? (pi_pending_i && !r_served) : r_grant;
    w_pi_rw_d  = (r_slot == 4'd5) ? pi_rw_b_i : r_pi_rw;
    w_rw_d     = (r_slot == 4'd8) ? bus_rw_b_i : r_rw;
    w_served_d = pi_pending_i && (r_served || ((r_slot == 4'd7) && r_grant));
    w_cpu_win  = (w_slot_nxt >= c_cpu_start) && (w_slot_nxt <= 4'd14);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_slot    <= 4'd0;
      r_clk8    <= 1'b0;
      r_served  <= 1'b0;
      r_grant   <= 1'b0;
      r_pi_rw   <= 1'b0;
      r_rw      <= 1'b1;
      r_phi2    <= 1'b0;
      r_cpu_en  <= 1'b0;
      r_cpu_rd  <= 1'b0;
      r_cpu_wr  <= 1'b0;
      r_vsel    <= 1'b0;
      r_vram    <= 1'b0;
      r_vrom    <= 1'b0;
      r_pi_sel  <= 1'b0;
      r_pi_rd   <= 1'b0;
      r_pi_wr   <= 1'b0;
      r_pi_done <= 1'b0;
    end else begin
      r_slot    <= w_slot_nxt;
      r_clk8    <= ~r_clk8;
      r_served  <= w_served_d;
      r_grant   <= w_grant_d;
      r_pi_rw   <= w_pi_rw_d;
      r_rw      <= w_rw_d;
      r_phi2    <= w_slot_nxt[3];
      r_cpu_en  <= w_slot_nxt[3];
      r_cpu_rd  <= w_cpu_win && w_rw_d;
      r_cpu_wr  <= w_cpu_win && !w_rw_d;
      r_vsel    <= c_video_en && (w_slot_nxt < 4'd6);
      r_vram    <= c_video_en && (w_slot_nxt == 4'd2);
      r_vrom    <= c_video_en && (w_slot_nxt == 4'd5);
      r_pi_sel  <= w_grant_d && ((w_slot_nxt == 4'd6) || (w_slot_nxt == 4'd7));
      r_pi_rd   <= w_grant_d && (w_slot_nxt == 4'd7) && w_pi_rw_d;
      r_pi_wr   <= w_grant_d && (w_slot_nxt == 4'd7) && !w_pi_rw_d;
      r_pi_done <= w_grant_d && (w_slot_nxt == 4'd8);
    end
  end

  assign cycle_o            = r_slot;
  assign clk8_o             = r_clk8;
  assign phi2_o             = r_phi2;
  assign cpu_enable_o       = r_cpu_en;
  assign cpu_read_o         = r_cpu_rd;
  assign cpu_write_o        = r_cpu_wr;
  assign video_select_o     = r_vsel;
  assign video_ram_strobe_o = r_vram;
  assign video_rom_strobe_o = r_vrom;
  assign pi_select_o        = r_pi_sel;
  assign pi_read_o          = r_pi_rd;
  assign pi_write_o         = r_pi_wr;
  assign pi_done_o          = r_pi_done;

endmodule
`default_nettype wire
